// File: rtl/dist_sq_pkg.sv
// Shared definitions for the squared-distance engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dist_sq_pkg;

  // Default result width; operands are half this width.
  localparam int DIST_SQ_BIT_WIDTH = 16;

  // Controller states: capture, square |dx|, square |dy|, publish.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_X = 2'd1,
    SQ_Y = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/shift_add_step.sv
// One shift-add multiply step: adds the shifted multiplicand when the multiplier bit is set.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module shift_add_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] mcand_in,
  input  logic         bit_in,
  output logic [W-1:0] acc_out
);

  // Conditional add of the current partial product; the only adder in the engine.
  always_comb begin
    acc_out = acc_in + (bit_in ? mcand_in : {W{1'b0}});
  end

endmodule

// File: rtl/dist_sq_seq.sv
// Sequential dx^2+dy^2 using one shared shift-add datapath over signed operand magnitudes.
// Latency: start at edge k -> finish/d_out valid in the cycle after edge k+2H+1.
// Backpressure: none; start is ignored while busy, one result per 2H+2 cycles.
import dist_sq_pkg::*;

module dist_sq_seq #(
  parameter int BIT_WIDTH = DIST_SQ_BIT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BIT_WIDTH/2-1:0] dx_in,
  input  logic [BIT_WIDTH/2-1:0] dy_in,
  output logic                   busy,
  output logic [BIT_WIDTH-1:0]   d_out,
  output logic                   finish
);

  localparam int H  = BIT_WIDTH / 2;
  localparam int CW = $clog2(H) + 1;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] acc_q, acc_d;
  logic [BIT_WIDTH-1:0] mcand_q, mcand_d;
  logic [H-1:0]         mplier_q, mplier_d;
  logic [H-1:0]         mag_y_q, mag_y_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] d_out_q, d_out_d;
  logic                 finish_q, finish_d;

  logic [H-1:0]         abs_x, abs_y;
  logic [BIT_WIDTH-1:0] step_acc;
  logic                 last_bit;

  // Two's-complement magnitudes; -2^(H-1) maps to 2^(H-1) as an unsigned H-bit value.
  always_comb begin
    abs_x = dx_in[H-1] ? (~dx_in + {{(H-1){1'b0}}, 1'b1}) : dx_in;
    abs_y = dy_in[H-1] ? (~dy_in + {{(H-1){1'b0}}, 1'b1}) : dy_in;
  end

  // Single adder shared by both squaring phases; the registers are reloaded between them.
  shift_add_step #(.W(BIT_WIDTH)) u_step (
    .acc_in   (acc_q),
    .mcand_in (mcand_q),
    .bit_in   (mplier_q[0]),
    .acc_out  (step_acc)
  );

  // Next-state and datapath control for the capture / square / square / publish sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mag_y_d  = mag_y_q;
    cnt_d    = cnt_q;
    d_out_d  = d_out_q;
    finish_d = 1'b0;
    last_bit = (cnt_q == CW'(H - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{(BIT_WIDTH-H){1'b0}}, abs_x};
          mplier_d = abs_x;
          mag_y_d  = abs_y;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = SQ_X;
        end
      end
      SQ_X: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          // Start the second square on the captured |dy|, accumulating on top of dx^2.
          mcand_d  = {{(BIT_WIDTH-H){1'b0}}, mag_y_q};
          mplier_d = mag_y_q;
          cnt_d    = '0;
          state_d  = SQ_Y;
        end
      end
      SQ_Y: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        d_out_d  = acc_q;
        finish_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mag_y_q  <= '0;
      cnt_q    <= '0;
      d_out_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mag_y_q  <= mag_y_d;
      cnt_q    <= cnt_d;
      d_out_q  <= d_out_d;
      finish_q <= finish_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign d_out  = d_out_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_dist_sq_seq.sv
// Randomised self-checking bench for dist_sq_seq against an arithmetic reference model.
// Latency: checks finish arrives 2H+1 edges after the capturing edge.
// Backpressure: checks start is ignored while busy and held-start throughput.
module tb_dist_sq_seq;

  localparam int BW = 16;
  localparam int H  = BW / 2;
  localparam int LAT = 2 * H + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [H-1:0]  dx_in;
  logic [H-1:0]  dy_in;
  logic          busy;
  logic [BW-1:0] d_out;
  logic          finish;

  int checks;
  int errors;

  dist_sq_seq #(.BIT_WIDTH(BW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dx_in  (dx_in),
    .dy_in  (dy_in),
    .busy   (busy),
    .d_out  (d_out),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the operands.
  function automatic int model(input logic [H-1:0] a, input logic [H-1:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return ia * ia + ib * ib;
  endfunction

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Called at a sample point (#1 after an edge) with the DUT idle.
  task automatic run_op(input logic [H-1:0] dx, input logic [H-1:0] dy,
                        output int lat, output int bcnt, output logic [BW-1:0] res);
    dx_in = dx;
    dy_in = dy;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dx_in = H'($urandom);
    dy_in = H'($urandom);
    bcnt  = int'(busy);
    lat   = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (finish) break;
      bcnt += int'(busy);
    end
    res = d_out;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat, bcnt, nf, last_f;
    logic [BW-1:0] res;
    logic [H-1:0] a, b;
    logic prev_f;
    int exp_v;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    dx_in = '0;
    dy_in = '0;
    idle_cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_dout", d_out, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    dx_in = 8'd7;
    idle_cycles(1);
    chk("rst_prio_busy", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    idle_cycles(2);
    chk("idle_busy", busy, 0);

    // 3,4 -> 25, latency and busy width.
    run_op(8'd3, 8'd4, lat, bcnt, res);
    chk("p34_lat", lat, LAT);
    chk("p34_busy", bcnt, LAT);
    chk("p34_dout", res, 25);
    chk("p34_busy_after", busy, 0);
    idle_cycles(1);
    chk("p34_finish_1wide", finish, 0);
    idle_cycles(4);
    chk("p34_dout_hold", d_out, 25);

    run_op(8'h80, 8'h80, lat, bcnt, res);
    chk("neg_max_dout", res, 32768);
    run_op(8'd127, 8'hFF, lat, bcnt, res);
    chk("p127_m1_dout", res, 16130);
    run_op(8'd0, 8'd0, lat, bcnt, res);
    chk("zero_dout", res, 0);
    chk("zero_lat", lat, LAT);

    // Start held high: a result every 2H+2 cycles, each finish one cycle wide.
    idle_cycles(1);
    dx_in = 8'd5;
    dy_in = 8'd12;
    start = 1'b1;
    nf = 0;
    last_f = -1;
    prev_f = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        nf++;
        chk("hold_dout", d_out, 169);
        chk("hold_1wide", prev_f, 0);
        if (last_f >= 0) chk("hold_gap", cyc - last_f, 2 * H + 2);
        last_f = cyc;
      end
      prev_f = finish;
    end
    chk("hold_count", nf, 4);
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) idle_cycles(1);
    chk("hold_drain", busy, 0);
    idle_cycles(1);

    // Reset 6 cycles into an operation aborts it.
    dx_in = 8'd10;
    dy_in = 8'd10;
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(6);
    reset = 1'b1;
    idle_cycles(1);
    chk("abort_dout", d_out, 0);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    // Start presented in the first cycle after reset releases.
    run_op(8'd1, 8'd1, lat, bcnt, res);
    chk("post_rst_lat", lat, LAT);
    chk("post_rst_dout", res, 2);
    nf = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (finish) nf++;
    end
    chk("no_stray_finish", nf, 0);

    // Random operand pairs; d_out also feeds a floor-sqrt stage checked against real sqrt.
    for (int n = 0; n < 1000; n++) begin
      a = H'($urandom);
      b = H'($urandom);
      exp_v = model(a, b);
      run_op(a, b, lat, bcnt, res);
      chk("rand_dout", res, exp_v);
      chk("rand_lat", lat, LAT);
      chk("rand_sqrt", isqrt(int'(res)), int'($floor($sqrt(real'(exp_v)))));
      if ((n % 7) == 3) idle_cycles(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dist_sq_seq.md
DIST_SQ_SEQ -- requirements
Module: dist_sq_seq

Interface
REQ-001 Parameter BIT_WIDTH, default 16, result width; operand width H = BIT_WIDTH/2; BIT_WIDTH even and >= 4.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dx_in  input  H  signed two's-complement x offset.
REQ-006 dy_in  input  H  signed two's-complement y offset.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 d_out  output  BIT_WIDTH  unsigned dx^2+dy^2, connects directly to x_in of the downstream sqrt_pipe.
REQ-009 finish  output  1  one-cycle pulse, d_out valid; drives start of the downstream sqrt_pipe.

Function
REQ-010 States: IDLE, SQ_X, SQ_Y, DONE; one-hot or binary encoding free.
REQ-011 IDLE with start=1 at an edge: capture |dx_in| and |dy_in| as H-bit unsigned magnitudes, clear accumulator and bit counter, go to SQ_X.
REQ-012 IDLE with start=0: remain in IDLE; d_out unchanged.
REQ-013 SQ_X: one shift-add step per cycle on the |dx| magnitude (multiplicand = multiplier = |dx|), H cycles, then SQ_Y with counter cleared.
REQ-014 SQ_Y: same H-cycle shift-add of |dy|, added into the same accumulator, then DONE.
REQ-015 DONE: d_out <= accumulator, finish=1 for exactly this cycle, next state IDLE.
REQ-016 Latency: start sampled at edge k -> finish high in the cycle after edge k+2H+1 (17 edges for BIT_WIDTH=16); throughput one result per 2H+2 cycles.
REQ-017 Magnitude of most-negative operand (-2^(H-1)) is 2^(H-1) unsigned, no overflow; max result 2^(BIT_WIDTH-1) (32768 for 16) fits BIT_WIDTH, no saturation logic.
REQ-018 Accumulator width BIT_WIDTH; no intermediate truncation.
REQ-019 start while busy=1 is ignored, including during DONE; operands re-sampled only at next IDLE.
REQ-020 d_out holds last result from DONE until the next DONE; changes only in DONE.
REQ-021 finish never asserted for two consecutive cycles.
REQ-022 dx_in/dy_in changes after the capture edge do not affect the current result.

Reset
REQ-023 reset=1 at an edge: state IDLE, busy=0, finish=0, d_out=0, accumulator and counter 0.
REQ-024 reset mid-operation aborts the computation with no finish pulse; a start in the first cycle after reset deasserts is accepted.
REQ-025 reset has priority over start at the same edge.

Structure
REQ-026 Shared package dist_sq_pkg holds the state enum type and default BIT_WIDTH constant.
REQ-027 One sub-module, shift_add_step: combinational single-bit multiply-accumulate step (accumulator, shifted multiplicand, multiplier LSB in -> next accumulator out), reused in SQ_X and SQ_Y.
REQ-028 No hardware multiplier inferred; one adder datapath total.

Verification
REQ-029 dx=3, dy=4, start pulse -> finish 17 edges later, d_out=25, busy high for 17 cycles.
REQ-030 dx=-128, dy=-128 -> d_out=32768; dx=127, dy=-1 -> d_out=16130.
REQ-031 dx=0, dy=0 -> d_out=0 with finish pulse at normal latency.
REQ-032 start=1 held continuously with dx=5, dy=12 -> finish every 18 cycles, d_out=169, finish never two cycles wide.
REQ-033 start with dx=10, dy=10, reset asserted 6 cycles later -> no finish, d_out=0; next start dx=1, dy=1 -> d_out=2.
REQ-034 Random 1000 operand pairs, checked against a reference model of dx*dx+dy*dy, plus chained into sqrt_pipe: floor(sqrt) output matches the model.
